tone_mix_pwm: RTL and testbench
===============================

// Module: tone_mix_pwm
// PURPOSE
//   Downstream of the 8-voice key-to-tone generator. Takes its 8 one-bit square-wave tone lines
//   plus the 8 key switches, counts the voices that are sounding, and scales that count by an
//   attack/release gain envelope. Drives a single 8-bit PWM audio pin (speaker/RC filter)
//   with click-free note on/off.
// PARAMETERS
//   SYNC_STAGES  2   flip-flop stages on key_in (asynchronous switches); minimum 2
//   RAMP_DIV     16  sample strobes per envelope gain step (1..255)
// PORTS
//   clk            in   1  system clock; all logic on rising edge
//   rst            in   1  synchronous, active-high reset
//   tone_in        in   8  tone-generator outputs, one per voice (same clock domain)
//   key_in         in   8  raw key switches sw[7:0], asynchronous
//   pwm_out        out  1  PWM audio output, 256-clock period
//   sample_strobe  out  1  one-cycle pulse at the end of each PWM period
//   level_out      out  4  active-voice count latched at the last strobe (0..8)
//   gain_out       out  4  current envelope gain (0..15)
// BEHAVIOUR
//   Reset: pwm_out=0, sample_strobe=0, level_out=0, gain_out=0, pwm_cnt=0, duty=0, ramp_cnt=0,
//     synchronizers cleared, state=IDLE. Reset asserted mid-operation gives these values on the
//     next edge; no partial period is finished.
//   Input path: key_in -> SYNC_STAGES-flop synchronizer -> key_s. tone_in -> one register -> tone_r.
//   pwm_cnt: 8-bit free-running, 255 wraps to 0.
//     sample_strobe is registered and is high for the cycle after pwm_cnt==255, i.e. pwm_cnt==0.
//     First strobe after reset release comes 256 cycles later.
//   At each strobe edge (pwm_cnt==255), the following load together:
//     level = popcount(tone_r & key_s) (0..8); a tone bit whose key is off is ignored.
//     duty  = level * gain * 2, using gain before this strobe's update. Range 0..240, no saturation.
//     level_out = level.
//     Envelope step is applied (below).
//   pwm_out is registered: pwm_out = (pwm_cnt < duty).
//     duty=0 gives constant low; duty=240 gives 240 high cycles per 256.
//     New duty takes effect from the first cycle of the next period; no glitch mid-period.
//   Envelope FSM (evaluated only at strobe; key_any = |key_s):
//     IDLE    gain=0.      key_any -> ATTACK.
//     ATTACK  !key_any -> RELEASE.
//             Else, on step: gain+1; if gain becomes 15 -> SUSTAIN.
//     SUSTAIN gain=15.     !key_any -> RELEASE.
//     RELEASE key_any -> ATTACK, resuming from the current gain with no jump.
//             Else, on step: gain-1; if gain becomes 0 -> IDLE.
//   Step rule: ramp_cnt counts strobes while in ATTACK/RELEASE.
//     A step occurs at a strobe where ramp_cnt==RAMP_DIV-1; ramp_cnt then returns to 0.
//     ramp_cnt clears to 0 on every state transition.
//     The gain change and the transition out of IDLE never happen in the same strobe.
//   Width rules: level 4b, gain 4b, product 7b, duty 8b. gain never wraps (clamped at 0 and 15 by the FSM).
//   Key toggles between strobes are invisible; only the value sampled at the strobe counts.
// TESTING (bench uses RAMP_DIV=2 unless stated)
//   1 Reset: rst high 3 cycles with key_in=FF, tone_in=FF
//     -> all outputs 0; first sample_strobe exactly 256 cycles after rst falls.
//   2 Attack: key_in=01, tone_in=01 constant
//     -> level_out=1; gain 0->15 in 1 step per 2 strobes (30 strobes after ATTACK entry);
//        then pwm_out high 30 of every 256 cycles.
//   3 Full chord: key_in=FF, tone_in=FF, gain=15
//     -> duty=240; pwm_out high exactly 240 cycles/period.
//   4 Release: key_in -> 00 in SUSTAIN
//     -> gain 15->0 over 30 strobes; state IDLE; pwm_out constant 0 afterwards.
//   5 Retrigger: key pressed again in RELEASE at gain=7
//     -> ATTACK; gain 7 -> 8 after 2 strobes; never drops to 0.
//   6 Masking and reset: tone_in=FF, key_in=05 -> level_out=2.
//     Then rst pulsed mid-period -> pwm_out=0 and gain_out=0 on the next edge.

Source files
------------

// File: rtl/tone_mix_pwm.sv
// Mixes up to 8 keyed square-wave voices into a voice count, scales it by an
// attack/release gain envelope and drives a 256-clock PWM audio pin.
module tone_mix_pwm #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RAMP_DIV    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tone_in,
  input  logic [7:0] key_in,
  output logic       pwm_out,
  output logic       sample_strobe,
  output logic [3:0] level_out,
  output logic [3:0] gain_out
);

  localparam int unsigned VoiceW = 8;
  localparam int unsigned CntW   = 8;
  localparam int unsigned LevelW = 4;
  localparam int unsigned GainW  = 4;
  localparam int unsigned ProdW  = 7;
  localparam int unsigned RampW  = 8;

  localparam logic [GainW-1:0] GainMax  = GainW'(15);
  localparam logic [GainW-1:0] GainMin  = GainW'(0);
  localparam logic [RampW-1:0] RampLast = RampW'(RAMP_DIV - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(255);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } envState_t;

  logic [VoiceW-1:0] keySync [SYNC_STAGES];
  logic [VoiceW-1:0] keyS;
  logic [VoiceW-1:0] toneR;
  logic [CntW-1:0]   pwmCnt;
  logic [CntW-1:0]   duty;
  logic [RampW-1:0]  rampCnt;
  logic [RampW-1:0]  rampNext;
  logic [GainW-1:0]  gainNext;
  logic [GainW-1:0]  gainUp;
  logic [GainW-1:0]  gainDn;
  logic [LevelW-1:0] level;
  logic [ProdW-1:0]  prod;
  logic              strobeEdge;
  logic              keyAny;
  logic              step;
  envState_t         state;
  envState_t         nextState;

  // Key switches are asynchronous; tone lines share our clock and need one register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) keySync[i] <= '0;
      toneR <= '0;
    end else begin
      keySync[0] <= key_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) keySync[i] <= keySync[i-1];
      toneR <= tone_in;
    end
  end

  assign keyS       = keySync[SYNC_STAGES-1];
  assign keyAny     = |keyS;
  assign strobeEdge = (pwmCnt == CntLast);
  assign step       = (rampCnt == RampLast);
  assign gainUp     = (gain_out == GainMax) ? GainMax : gain_out + GainW'(1);
  assign gainDn     = (gain_out == GainMin) ? GainMin : gain_out - GainW'(1);

  // Count only voices whose key is actually held.
  always_comb begin
    level = '0;
    for (int i = 0; i < int'(VoiceW); i++) level = level + LevelW'(toneR[i] & keyS[i]);
  end

  assign prod = ProdW'(level) * ProdW'(gain_out);

  // Envelope state register, advanced only at the end of a PWM period.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (strobeEdge) state <= nextState;
  end

  // Envelope next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (keyAny) nextState = ATTACK;
      ATTACK: begin
        if (!keyAny) nextState = RELEASE;
        else if (step && gainUp == GainMax) nextState = SUSTAIN;
      end
      SUSTAIN: if (!keyAny) nextState = RELEASE;
      RELEASE: begin
        if (keyAny) nextState = ATTACK;
        else if (step && gainDn == GainMin) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Envelope gain and ramp-divider updates; a retrigger keeps the current gain.
  always_comb begin
    gainNext = gain_out;
    rampNext = rampCnt;
    case (state)
      IDLE:    gainNext = GainMin;
      ATTACK:  if (keyAny && step) gainNext = gainUp;
      SUSTAIN: gainNext = GainMax;
      RELEASE: if (!keyAny && step) gainNext = gainDn;
      default: gainNext = GainMin;
    endcase
    if (nextState != state || step) rampNext = '0;
    else if (state == ATTACK || state == RELEASE) rampNext = rampCnt + RampW'(1);
    else rampNext = '0;
  end

  // PWM counter, per-period sample registers and the output pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwmCnt        <= '0;
      duty          <= '0;
      rampCnt       <= '0;
      sample_strobe <= 1'b0;
      pwm_out       <= 1'b0;
      level_out     <= '0;
      gain_out      <= '0;
    end else begin
      pwmCnt        <= pwmCnt + CntW'(1);
      sample_strobe <= strobeEdge;
      pwm_out       <= (pwmCnt < duty);
      if (strobeEdge) begin
        duty      <= {prod, 1'b0};
        level_out <= level;
        gain_out  <= gainNext;
        rampCnt   <= rampNext;
      end
    end
  end

endmodule

// File: tb/tb_tone_mix_pwm.sv
// Scoreboard bench for tone_mix_pwm: a behavioural envelope model queues the
// expected level/gain/duty per strobe; a monitor pops and checks each period.
module tb_tone_mix_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tone_in = 8'hFF;
  logic [7:0] key_in = 8'hFF;
  logic       pwm_out;
  logic       sample_strobe;
  logic [3:0] level_out;
  logic [3:0] gain_out;

  typedef struct {
    int level;
    int gain;
    int duty;
  } expect_t;

  expect_t sbQ[$];
  int testCount = 0;
  int failCount = 0;
  int strobeNo  = 0;

  // Reference envelope model: 0 idle, 1 attack, 2 sustain, 3 release.
  int mState = 0;
  int mGain  = 0;
  int mRamp  = 0;

  tone_mix_pwm #(.SYNC_STAGES(2), .RAMP_DIV(2)) dut (
    .clk(clk),
    .rst(rst),
    .tone_in(tone_in),
    .key_in(key_in),
    .pwm_out(pwm_out),
    .sample_strobe(sample_strobe),
    .level_out(level_out),
    .gain_out(gain_out)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    testCount++;
    if (got != exp) begin
      failCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelStep(input logic [7:0] key, input logic [7:0] tone);
    expect_t e;
    int  lvl;
    bit  any;
    bit  stepNow;
    lvl = $countones(key & tone);
    any = (key != 8'h00);
    e.level = lvl;
    e.duty  = lvl * mGain * 2;
    stepNow = (mRamp == 1);
    case (mState)
      0: if (any) begin mState = 1; mRamp = 0; end
      1: begin
        if (!any) begin mState = 3; mRamp = 0; end
        else if (stepNow) begin
          mGain = mGain + 1; mRamp = 0;
          if (mGain == 15) mState = 2;
        end else mRamp = mRamp + 1;
      end
      2: if (!any) begin mState = 3; mRamp = 0; end
      default: begin
        if (any) begin mState = 1; mRamp = 0; end
        else if (stepNow) begin
          mGain = mGain - 1; mRamp = 0;
          if (mGain == 0) mState = 0;
        end else mRamp = mRamp + 1;
      end
    endcase
    e.gain = mGain;
    sbQ.push_back(e);
  endtask

  task automatic waitStrobe(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!sample_strobe && cyc < 600);
  endtask

  // Drive one input pattern for n strobes, queuing the model's expectations up front.
  task automatic runPhase(input logic [7:0] key, input logic [7:0] tone, input int n);
    int cyc;
    key_in  = key;
    tone_in = tone;
    for (int i = 0; i < n; i++) modelStep(key, tone);
    for (int i = 0; i < n; i++) begin
      waitStrobe(cyc);
      checkVal("periodLen", cyc, 256);
    end
  endtask

  // Monitor: at each strobe check level/gain and the high count of the finished period.
  initial begin
    int      hiCount;
    int      pendingDuty;
    bit      dutyPending;
    expect_t e;
    hiCount = 0;
    pendingDuty = 0;
    dutyPending = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hiCount = 0;
        dutyPending = 0;
      end else begin
        if (sample_strobe) begin
          strobeNo++;
          if (dutyPending)
            checkVal($sformatf("pwmHigh#%0d", strobeNo - 1), hiCount, pendingDuty);
          hiCount = 0;
          checkVal($sformatf("sbNonEmpty#%0d", strobeNo), int'(sbQ.size() > 0), 1);
          if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkVal($sformatf("level#%0d", strobeNo), int'(level_out), e.level);
            checkVal($sformatf("gain#%0d", strobeNo), int'(gain_out), e.gain);
            pendingDuty = e.duty;
            dutyPending = 1;
          end
        end
        hiCount += int'(pwm_out);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rstPwm", int'(pwm_out), 0);
    checkVal("rstStrobe", int'(sample_strobe), 0);
    checkVal("rstLevel", int'(level_out), 0);
    checkVal("rstGain", int'(gain_out), 0);
    rst = 1'b0;

    runPhase(8'h01, 8'h01, 34);
    runPhase(8'hFF, 8'hFF, 3);
    runPhase(8'h00, 8'hFF, 32);
    runPhase(8'h01, 8'h01, 31);
    runPhase(8'h00, 8'h01, 17);
    checkVal("preRetrigGain", int'(gain_out), 7);
    runPhase(8'h01, 8'h01, 4);
    runPhase(8'h05, 8'hFF, 2);

    // Reset in the middle of a period.
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkVal("midRstPwm", int'(pwm_out), 0);
    checkVal("midRstGain", int'(gain_out), 0);
    checkVal("midRstLevel", int'(level_out), 0);
    checkVal("midRstStrobe", int'(sample_strobe), 0);
    mState = 0;
    mGain  = 0;
    mRamp  = 0;
    @(negedge clk);
    rst = 1'b0;
    runPhase(8'h00, 8'hFF, 2);

    repeat (3) @(negedge clk);
    checkVal("sbDrained", int'(sbQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
